// File: rtl/xbar_pkg.sv
// xbar_pkg: shared crossbar constants, FSM state type and one-hot request helper
package xbar_pkg;
    localparam int NUM_PORTS = 16;
    localparam int PORT_W = 4;
    typedef enum logic [1:0] {IDLE, REQ, SEND, COOL} state_t;
    function automatic logic [NUM_PORTS-1:0] port_onehot(input logic [PORT_W-1:0] p);
        return {{(NUM_PORTS-1){1'b0}}, 1'b1} << p;
    endfunction
endpackage

// File: rtl/xbar_input_queue_if.sv
// xbar_input_queue_if: ingress flit handshake, arbiter request/grant and fabric egress
interface xbar_input_queue_if #(parameter int DATA_W = 32, parameter int DEPTH = 8);
    import xbar_pkg::*;
    logic in_valid;
    logic in_ready;
    logic [DATA_W-1:0] in_data;
    logic [PORT_W-1:0] in_dest;
    logic [NUM_PORTS-1:0] request;
    logic [NUM_PORTS-1:0] grant_in;
    logic out_valid;
    logic [DATA_W-1:0] out_data;
    logic [PORT_W-1:0] out_dest;
    logic [$clog2(DEPTH):0] fifo_count;
    modport slave (
        input in_valid, in_data, in_dest, grant_in,
        output in_ready, request, out_valid, out_data, out_dest, fifo_count
    );
    modport master (
        output in_valid, in_data, in_dest, grant_in,
        input in_ready, request, out_valid, out_data, out_dest, fifo_count
    );
endinterface

// File: rtl/xbar_sync_fifo.sv
// xbar_sync_fifo: synchronous FIFO; count tells full from empty since pointers wrap mod DEPTH
module xbar_sync_fifo #(
    parameter int WIDTH = 36,
    parameter int DEPTH = 8
) (
    input  logic clock,
    input  logic reset,
    input  logic push,
    input  logic pop,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] rd_data,
    output logic full,
    output logic empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic do_push, do_pop;
    assign do_push = push && !full;
    assign do_pop = pop && !empty;
    assign full = count == (AW+1)'(DEPTH);
    assign empty = count == '0;
    assign rd_data = mem[rd_ptr];
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count <= '0;
        end else begin
            wr_ptr <= wr_ptr + AW'(do_push);
            rd_ptr <= rd_ptr + AW'(do_pop);
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end
    always_ff @(posedge clock)
        if (do_push) mem[wr_ptr] <= wr_data;
endmodule

// File: rtl/xbar_input_queue.sv
// xbar_input_queue: per-input ingress queue; requests the head's output, forwards on grant,
// then holds request low for GNT_LAT cycles so in-flight arbiter grants drain.
module xbar_input_queue
    import xbar_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DEPTH = 8,
    parameter int GNT_LAT = 4
) (
    input logic clock,
    input logic reset,
    xbar_input_queue_if.slave bus
);
    localparam int CW = $clog2(GNT_LAT + 1);
    state_t state, state_n;
    logic [CW-1:0] cool;
    logic [PORT_W+DATA_W-1:0] head;
    logic [PORT_W-1:0] head_dest;
    logic full, empty, push, pop;
    assign head_dest = head[DATA_W +: PORT_W];
    assign push = bus.in_valid && !full;
    assign pop = state == SEND;
    assign bus.in_ready = !full;
    xbar_sync_fifo #(.WIDTH(PORT_W + DATA_W), .DEPTH(DEPTH)) u_fifo (
        .clock(clock),
        .reset(reset),
        .push(push),
        .pop(pop),
        .wr_data({bus.in_dest, bus.in_data}),
        .rd_data(head),
        .full(full),
        .empty(empty),
        .count(bus.fifo_count)
    );
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
            cool <= '0;
        end else begin
            state <= state_n;
            cool <= state == SEND ? CW'(GNT_LAT) : state == COOL ? cool - 1'b1 : cool;
        end
    end
    // COOL exits on the cycle the counter runs out, giving exactly GNT_LAT cycles low
    always_comb begin
        state_n = state;
        state_n = state == IDLE ? (empty ? IDLE : REQ)
                : state == REQ  ? (bus.grant_in[head_dest] ? SEND : REQ)
                : state == SEND ? COOL
                : (cool == CW'(1) ? (empty ? IDLE : REQ) : COOL);
    end
    assign bus.request = state == REQ ? port_onehot(head_dest) : '0;
    assign bus.out_valid = pop;
    assign bus.out_data = pop ? head[DATA_W-1:0] : '0;
    assign bus.out_dest = pop ? head_dest : '0;
endmodule

// File: tb/tb_xbar_input_queue.sv
// tb_xbar_input_queue: directed stimulus checked every cycle against a queue-based model,
// plus hand-computed literal expectations per scenario.
module tb_xbar_input_queue;
    import xbar_pkg::*;
    localparam int DATA_W = 32;
    localparam int DEPTH = 8;
    localparam int GNT_LAT = 4;
    logic clock = 0;
    logic reset = 1;
    always #5 clock = ~clock;
    xbar_input_queue_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) bus ();
    xbar_input_queue #(.DATA_W(DATA_W), .DEPTH(DEPTH), .GNT_LAT(GNT_LAT)) dut (
        .clock(clock),
        .reset(reset),
        .bus(bus)
    );
    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic [35:0] q[$];
    bit m_req = 0;
    bit m_send = 0;
    int m_cool = 0;
    logic [31:0] ov_data[$];
    int ov_cyc[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(negedge clock);
        #1;
    endtask

    task automatic push_one(input logic [3:0] d, input logic [31:0] v);
        bus.in_valid = 1;
        bus.in_dest = d;
        bus.in_data = v;
        tick();
        bus.in_valid = 0;
    endtask

    // Model: the queue holds accepted flits; a flit is forwarded the cycle after its
    // destination's grant is seen while requesting, then GNT_LAT quiet cycles follow.
    initial forever begin
        @(posedge clock);
        if (reset) begin
            q.delete();
            m_req = 0;
            m_send = 0;
            m_cool = 0;
        end else begin
            int n;
            bit pu;
            n = q.size();
            pu = bus.in_valid && n < DEPTH;
            if (m_send) begin
                void'(q.pop_front());
                m_send = 0;
                m_cool = GNT_LAT;
            end else if (m_cool > 0) begin
                m_cool--;
                if (m_cool == 0) m_req = n > 0;
            end else if (m_req) begin
                if (bus.grant_in[q[0][35:32]]) begin
                    m_req = 0;
                    m_send = 1;
                end
            end else begin
                m_req = n > 0;
            end
            if (pu) q.push_back({bus.in_dest, bus.in_data});
        end
        cyc++;
    end

    initial forever begin
        @(negedge clock);
        if (cyc > 0) begin
            chk("in_ready", 64'(bus.in_ready), 64'(q.size() < DEPTH));
            chk("fifo_count", 64'(bus.fifo_count), 64'(q.size()));
            chk("request", 64'(bus.request), m_req ? 64'(1) << q[0][35:32] : 64'(0));
            chk("out_valid", 64'(bus.out_valid), 64'(m_send));
            chk("out_data", 64'(bus.out_data), m_send ? 64'(q[0][31:0]) : 64'(0));
            chk("out_dest", 64'(bus.out_dest), m_send ? 64'(q[0][35:32]) : 64'(0));
            if (bus.out_valid) begin
                ov_data.push_back(bus.out_data);
                ov_cyc.push_back(cyc);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        bit got;
        int n;
        bus.in_valid = 0;
        bus.in_data = '0;
        bus.in_dest = '0;
        bus.grant_in = '0;
        repeat (2) tick();
        chk("rst_request", 64'(bus.request), 64'h0);
        chk("rst_in_ready", 64'(bus.in_ready), 64'h1);
        chk("rst_count", 64'(bus.fifo_count), 64'h0);
        chk("rst_out_valid", 64'(bus.out_valid), 64'h0);
        reset = 0;
        // single flit to port 5
        push_one(4'd5, 32'hA5A5_0001);
        chk("t1_count", 64'(bus.fifo_count), 64'h1);
        chk("t1_req_idle", 64'(bus.request), 64'h0);
        tick();
        chk("t1_request", 64'(bus.request), 64'h0020);
        repeat (2) tick();
        bus.grant_in = 16'h0020;
        tick();
        bus.grant_in = '0;
        chk("t1_out_valid", 64'(bus.out_valid), 64'h1);
        chk("t1_out_dest", 64'(bus.out_dest), 64'h5);
        chk("t1_out_data", 64'(bus.out_data), 64'hA5A5_0001);
        repeat (GNT_LAT) begin
            tick();
            chk("t1_cool_req", 64'(bus.request), 64'h0);
        end
        tick();
        chk("t1_idle_count", 64'(bus.fifo_count), 64'h0);
        chk("t1_idle_req", 64'(bus.request), 64'h0);
        // grant on the wrong bit is ignored
        push_one(4'd3, 32'h0000_0033);
        bus.grant_in = 16'h0001;
        tick();
        repeat (5) begin
            chk("t2_request", 64'(bus.request), 64'h0008);
            chk("t2_no_out", 64'(bus.out_valid), 64'h0);
            tick();
        end
        bus.grant_in = 16'h0008;
        tick();
        bus.grant_in = '0;
        chk("t2_out_valid", 64'(bus.out_valid), 64'h1);
        chk("t2_out_data", 64'(bus.out_data), 64'h33);
        repeat (GNT_LAT + 1) tick();
        // grant held through COOL: one transfer per window, period GNT_LAT+2
        push_one(4'd3, 32'h301);
        push_one(4'd3, 32'h302);
        chk("t3_request", 64'(bus.request), 64'h0008);
        ov_cyc.delete();
        ov_data.delete();
        bus.grant_in = 16'h0008;
        repeat (6) tick();
        chk("t3_one_pulse", 64'(ov_cyc.size()), 64'h1);
        repeat (6) tick();
        bus.grant_in = '0;
        chk("t3_two_pulses", 64'(ov_cyc.size()), 64'h2);
        if (ov_cyc.size() == 2) chk("t3_spacing", 64'(ov_cyc[1] - ov_cyc[0]), 64'(GNT_LAT + 2));
        chk("t3_order", 64'(ov_data[0]), 64'h301);
        repeat (2) tick();
        // fill to DEPTH, ninth flit refused until the first pop frees a slot
        bus.in_valid = 1;
        for (int i = 0; i < 8; i++) begin
            bus.in_dest = 4'(i * 3);
            bus.in_data = 32'(i);
            tick();
        end
        bus.in_dest = 4'd2;
        bus.in_data = 32'h100;
        tick();
        chk("t4_full_count", 64'(bus.fifo_count), 64'h8);
        chk("t4_full_ready", 64'(bus.in_ready), 64'h0);
        ov_data.delete();
        bus.grant_in = 16'hFFFF;
        got = 0;
        for (int k = 0; k < 20 && !got; k++) begin
            tick();
            if (bus.in_ready) begin
                tick();
                bus.in_valid = 0;
                got = 1;
            end
        end
        bus.in_valid = 0;
        chk("t4_accept", 64'(got), 64'h1);
        chk("t4_refill_count", 64'(bus.fifo_count), 64'h8);
        chk("t4_refill_ready", 64'(bus.in_ready), 64'h0);
        for (int k = 0; k < 100 && ov_data.size() < 9; k++) tick();
        chk("t4_drained", 64'(ov_data.size()), 64'h9);
        for (int i = 0; i < 8; i++) chk("t4_data", 64'(ov_data[i]), 64'(i));
        chk("t4_last", 64'(ov_data[8]), 64'h100);
        bus.grant_in = '0;
        repeat (GNT_LAT + 2) tick();
        // reset during COOL discards the queue
        for (int i = 0; i < 4; i++) push_one(4'd1, 32'h500 + 32'(i));
        bus.grant_in = 16'h0002;
        for (int k = 0; k < 30 && !bus.out_valid; k++) tick();
        chk("t5_pulse", 64'(bus.out_valid), 64'h1);
        bus.grant_in = '0;
        tick();
        chk("t5_cool_count", 64'(bus.fifo_count), 64'h3);
        reset = 1;
        tick();
        chk("t5_rst_count", 64'(bus.fifo_count), 64'h0);
        chk("t5_rst_request", 64'(bus.request), 64'h0);
        chk("t5_rst_ready", 64'(bus.in_ready), 64'h1);
        chk("t5_rst_out", 64'(bus.out_valid), 64'h0);
        reset = 0;
        bus.grant_in = 16'hFFFF;
        n = ov_data.size();
        repeat (10) tick();
        chk("t5_no_out", 64'(ov_data.size()), 64'(n));
        bus.grant_in = '0;
        tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
